// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a multicycle RV32-style datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB, times out stalled memory requests, and
// parks in a sticky FAULT state on an illegal opcode or a memory timeout.
// Level outputs are registered from the next state. The write strobes that
// must fire in the same cycle as a memory ready are qualified combinationally
// by that ready input and the current state.
module multicycle_control #(
  parameter int ALUOP_W = 3,
  parameter bit EN_JUMP = 1'b1,
  parameter int TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [6:0]         i_OPCode,
  input  logic               i_ImemReady,
  input  logic               i_DmemReady,
  output logic               o_ImemReq,
  output logic               o_DmemReq,
  output logic               o_DmemWe,
  output logic               o_IRWrite,
  output logic               o_PCWrite,
  output logic               o_RegWrite,
  output logic               o_Branch,
  output logic               o_Jump,
  output logic               o_MemToReg,
  output logic               o_ALUSrc1,
  output logic               o_ALUSrc2,
  output logic [ALUOP_W-1:0] o_ALUOp,
  output logic               o_Retire,
  output logic               o_Fault,
  output logic               o_Illegal,
  output logic [2:0]         o_State
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE   = 4'd0,
    CL_R      = 4'd1,
    CL_I      = 4'd2,
    CL_LOAD   = 4'd3,
    CL_STORE  = 4'd4,
    CL_BRANCH = 4'd5,
    CL_LUI    = 4'd6,
    CL_AUIPC  = 4'd7,
    CL_JAL    = 4'd8,
    CL_JALR   = 4'd9
  } cls_t;

  // State-decoded (Moore) outputs, held in one register.
  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       mem_to_reg;
    logic       alu_src1;
    logic       alu_src2;
    logic       retire;
    logic       fault;
    logic [2:0] alu_op;
  } mo_t;

  localparam logic [8:0] TIMEOUT_L = 9'(TIMEOUT);

  // Map an opcode to its instruction class; jumps are illegal when disabled.
  function automatic cls_t classify(input logic [6:0] op);
    cls_t cl;
    case (op)
      7'b0110011: cl = CL_R;
      7'b0010011: cl = CL_I;
      7'b0000011: cl = CL_LOAD;
      7'b0100011: cl = CL_STORE;
      7'b1100011: cl = CL_BRANCH;
      7'b0110111: cl = CL_LUI;
      7'b0010111: cl = CL_AUIPC;
      7'b1101111: cl = EN_JUMP ? CL_JAL : CL_NONE;
      7'b1100111: cl = EN_JUMP ? CL_JALR : CL_NONE;
      default:    cl = CL_NONE;
    endcase
    return cl;
  endfunction

  // Level outputs for a given state and instruction class.
  function automatic mo_t moore_out(input state_t st, input cls_t cl);
    mo_t mo;
    mo = '0;
    case (st)
      ST_FETCH: mo.imem_req = 1'b1;
      ST_EXEC: begin
        case (cl)
          CL_BRANCH:       mo.alu_op = 3'b001;
          CL_R:            mo.alu_op = 3'b010;
          CL_I:            mo.alu_op = 3'b011;
          CL_LUI:          mo.alu_op = 3'b100;
          CL_AUIPC:        mo.alu_op = 3'b101;
          CL_JAL, CL_JALR: mo.alu_op = 3'b110;
          default:         mo.alu_op = 3'b000;
        endcase
        mo.alu_src1 = (cl == CL_AUIPC) || (cl == CL_JAL);
        mo.alu_src2 = (cl != CL_R) && (cl != CL_BRANCH) && (cl != CL_NONE);
        mo.branch   = (cl == CL_BRANCH);
        mo.pc_write = (cl == CL_BRANCH);
        mo.retire   = (cl == CL_BRANCH);
      end
      ST_MEM: begin
        mo.dmem_req = 1'b1;
        mo.dmem_we  = (cl == CL_STORE);
      end
      ST_WB: begin
        mo.reg_write  = 1'b1;
        mo.pc_write   = 1'b1;
        mo.retire     = 1'b1;
        mo.mem_to_reg = (cl == CL_LOAD);
        mo.jump       = (cl == CL_JAL) || (cl == CL_JALR);
      end
      ST_FAULT: mo.fault = 1'b1;
      default:  mo = '0;
    endcase
    return mo;
  endfunction

  state_t     state_r;
  state_t     nxt_s;
  logic [6:0] op_r;
  logic [7:0] wait_r;
  logic [8:0] wait_inc_s;
  logic       illegal_r;
  mo_t        mo_r;
  cls_t       cls_s;
  cls_t       dec_cls_s;
  cls_t       nxt_cls_s;
  logic       store_done_s;
  logic       timeout_s;

  assign cls_s      = classify(op_r);
  assign dec_cls_s  = classify(i_OPCode);
  assign wait_inc_s = {1'b0, wait_r} + 9'd1;
  assign timeout_s  = (wait_inc_s == TIMEOUT_L);

  // Next-state decode; a ready seen on the timeout cycle still wins.
  always_comb begin
    nxt_s = ST_FAULT;
    case (state_r)
      ST_FETCH: begin
        if (i_ImemReady)    nxt_s = ST_DECODE;
        else if (timeout_s) nxt_s = ST_FAULT;
        else                nxt_s = ST_FETCH;
      end
      ST_DECODE: begin
        if (dec_cls_s == CL_NONE) nxt_s = ST_FAULT;
        else                      nxt_s = ST_EXEC;
      end
      ST_EXEC: begin
        if ((cls_s == CL_LOAD) || (cls_s == CL_STORE)) nxt_s = ST_MEM;
        else if (cls_s == CL_BRANCH)                   nxt_s = ST_FETCH;
        else                                           nxt_s = ST_WB;
      end
      ST_MEM: begin
        if (i_DmemReady) nxt_s = (cls_s == CL_LOAD) ? ST_WB : ST_FETCH;
        else if (timeout_s) nxt_s = ST_FAULT;
        else nxt_s = ST_MEM;
      end
      ST_WB:    nxt_s = ST_FETCH;
      ST_FAULT: nxt_s = ST_FAULT;
      default:  nxt_s = ST_FAULT;
    endcase
  end

  // Class used for the registered outputs: the opcode being captured in DECODE.
  always_comb begin
    if (state_r == ST_DECODE) nxt_cls_s = dec_cls_s;
    else                      nxt_cls_s = cls_s;
  end

  // FSM state, captured opcode, wait counter, fault cause and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r   <= ST_FETCH;
      op_r      <= 7'b0000000;
      wait_r    <= 8'd0;
      illegal_r <= 1'b0;
      mo_r      <= moore_out(ST_FETCH, CL_NONE);
    end else begin
      state_r <= nxt_s;
      mo_r    <= moore_out(nxt_s, nxt_cls_s);
      if (state_r == ST_DECODE) op_r <= i_OPCode;
      else                      op_r <= op_r;
      if ((nxt_s == state_r) && ((state_r == ST_FETCH) || (state_r == ST_MEM)))
        wait_r <= wait_inc_s[7:0];
      else
        wait_r <= 8'd0;
      if ((state_r == ST_DECODE) && (nxt_s == ST_FAULT)) illegal_r <= 1'b1;
      else                                               illegal_r <= illegal_r;
    end
  end

  assign store_done_s = (state_r == ST_MEM) && (cls_s == CL_STORE) && i_DmemReady;

  // Write strobes are suppressed while reset is held so an abandoned
  // instruction never retires.
  assign o_IRWrite  = i_rst_n && (state_r == ST_FETCH) && i_ImemReady;
  assign o_PCWrite  = i_rst_n && (mo_r.pc_write || store_done_s);
  assign o_Retire   = i_rst_n && (mo_r.retire || store_done_s);
  assign o_RegWrite = i_rst_n && mo_r.reg_write;

  assign o_ImemReq  = mo_r.imem_req;
  assign o_DmemReq  = mo_r.dmem_req;
  assign o_DmemWe   = mo_r.dmem_we;
  assign o_Branch   = mo_r.branch;
  assign o_Jump     = mo_r.jump;
  assign o_MemToReg = mo_r.mem_to_reg;
  assign o_ALUSrc1  = mo_r.alu_src1;
  assign o_ALUSrc2  = mo_r.alu_src2;
  assign o_ALUOp    = ALUOP_W'(mo_r.alu_op);
  assign o_Fault    = mo_r.fault;
  assign o_Illegal  = illegal_r;
  assign o_State    = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle trace checks of the control FSM
// on three parameterisations sharing one stimulus stream.
module tb_multicycle_control;

  localparam logic [13:0] F_IREQ = 14'h2000;
  localparam logic [13:0] F_DREQ = 14'h1000;
  localparam logic [13:0] F_DWE  = 14'h0800;
  localparam logic [13:0] F_IRW  = 14'h0400;
  localparam logic [13:0] F_PCW  = 14'h0200;
  localparam logic [13:0] F_RGW  = 14'h0100;
  localparam logic [13:0] F_BR   = 14'h0080;
  localparam logic [13:0] F_JMP  = 14'h0040;
  localparam logic [13:0] F_M2R  = 14'h0020;
  localparam logic [13:0] F_SRC1 = 14'h0010;
  localparam logic [13:0] F_SRC2 = 14'h0008;
  localparam logic [13:0] F_RET  = 14'h0004;
  localparam logic [13:0] F_FLT  = 14'h0002;
  localparam logic [13:0] F_ILL  = 14'h0001;
  localparam logic [13:0] F_NONE = 14'h0000;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct {
    logic [2:0]  st;
    logic [4:0]  alu;
    logic [13:0] fl;
    int          step;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        imr;
  logic        dmr;
  logic [6:0]  op;
  int          sel;
  string       tag;
  int          step;
  int          n_cmp;
  int          n_fail;
  exp_t        q[$];
  exp_t        e;

  wire  [13:0] fa, fb, fc;
  wire  [2:0]  alu_a, alu_b;
  wire  [4:0]  alu_c;
  wire  [2:0]  st_a, st_b, st_c;
  logic [13:0] obs_fl;
  logic [4:0]  obs_alu;
  logic [2:0]  obs_st;

  multicycle_control dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_OPCode(op), .i_ImemReady(imr), .i_DmemReady(dmr),
    .o_ImemReq(fa[13]), .o_DmemReq(fa[12]), .o_DmemWe(fa[11]), .o_IRWrite(fa[10]),
    .o_PCWrite(fa[9]), .o_RegWrite(fa[8]), .o_Branch(fa[7]), .o_Jump(fa[6]),
    .o_MemToReg(fa[5]), .o_ALUSrc1(fa[4]), .o_ALUSrc2(fa[3]), .o_ALUOp(alu_a),
    .o_Retire(fa[2]), .o_Fault(fa[1]), .o_Illegal(fa[0]), .o_State(st_a)
  );

  multicycle_control #(.ALUOP_W(3), .EN_JUMP(1'b0), .TIMEOUT(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_OPCode(op), .i_ImemReady(imr), .i_DmemReady(dmr),
    .o_ImemReq(fb[13]), .o_DmemReq(fb[12]), .o_DmemWe(fb[11]), .o_IRWrite(fb[10]),
    .o_PCWrite(fb[9]), .o_RegWrite(fb[8]), .o_Branch(fb[7]), .o_Jump(fb[6]),
    .o_MemToReg(fb[5]), .o_ALUSrc1(fb[4]), .o_ALUSrc2(fb[3]), .o_ALUOp(alu_b),
    .o_Retire(fb[2]), .o_Fault(fb[1]), .o_Illegal(fb[0]), .o_State(st_b)
  );

  multicycle_control #(.ALUOP_W(5), .EN_JUMP(1'b1), .TIMEOUT(15)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_OPCode(op), .i_ImemReady(imr), .i_DmemReady(dmr),
    .o_ImemReq(fc[13]), .o_DmemReq(fc[12]), .o_DmemWe(fc[11]), .o_IRWrite(fc[10]),
    .o_PCWrite(fc[9]), .o_RegWrite(fc[8]), .o_Branch(fc[7]), .o_Jump(fc[6]),
    .o_MemToReg(fc[5]), .o_ALUSrc1(fc[4]), .o_ALUSrc2(fc[3]), .o_ALUOp(alu_c),
    .o_Retire(fc[2]), .o_Fault(fc[1]), .o_Illegal(fc[0]), .o_State(st_c)
  );

  // Route the instance under test to the monitor.
  always_comb begin
    case (sel)
      0:       begin obs_fl = fa; obs_alu = {2'b00, alu_a}; obs_st = st_a; end
      1:       begin obs_fl = fb; obs_alu = {2'b00, alu_b}; obs_st = st_b; end
      default: begin obs_fl = fc; obs_alu = alu_c;          obs_st = st_c; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every cycle with a queued expectation, pop it and compare.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if ((obs_st !== e.st) || (obs_alu !== e.alu) || (obs_fl !== e.fl)) begin
        n_fail++;
        $display("FAIL %s step %0d: got st=%0d alu=%b flags=%b, expected st=%0d alu=%b flags=%b",
                 tag, e.step, obs_st, obs_alu, obs_fl, e.st, e.alu, e.fl);
      end
    end
  end

  // Drive one cycle of inputs and optionally queue the expected outputs.
  task automatic cyc(input logic r, input logic im, input logic dm, input logic [6:0] o,
                     input bit chk, input logic [2:0] es, input logic [4:0] ea,
                     input logic [13:0] ef);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = r; imr = im; dmr = dm; op = o;
    if (chk) begin
      step++;
      x.st = es; x.alu = ea; x.fl = ef; x.step = step;
      q.push_back(x);
    end
  endtask

  task automatic chk(input logic im, input logic dm, input logic [6:0] o,
                     input logic [2:0] es, input logic [4:0] ea, input logic [13:0] ef);
    cyc(1'b1, im, dm, o, 1'b1, es, ea, ef);
  endtask

  task automatic do_reset(input int s, input string t);
    cyc(1'b0, 1'b0, 1'b0, 7'b0000000, 1'b0, 3'd0, 5'd0, F_NONE);
    sel = s; tag = t; step = 0;
  endtask

  // Fetch, decode, one-cycle EXEC, WB, back to FETCH; opcode scrambled after DECODE.
  task automatic alu_instr(input logic [6:0] o, input logic [4:0] ea,
                           input logic [13:0] fx, input logic [13:0] fw);
    chk(1'b1, 1'b0, o, 3'd0, 5'd0, F_IREQ | F_IRW);
    chk(1'b0, 1'b0, o, 3'd1, 5'd0, F_NONE);
    chk(1'b0, 1'b0, OP_BAD, 3'd2, ea, fx);
    chk(1'b0, 1'b0, OP_BAD, 3'd4, 5'd0, fw);
    chk(1'b0, 1'b0, OP_BAD, 3'd0, 5'd0, F_IREQ);
  endtask

  initial begin
    rst_n = 1'b0; imr = 1'b0; dmr = 1'b0; op = 7'b0000000;
    sel = 0; tag = "init"; step = 0; n_cmp = 0; n_fail = 0;

    do_reset(0, "reset_state");
    chk(1'b0, 1'b0, 7'b0000000, 3'd0, 5'd0, F_IREQ);

    tag = "rtype";
    alu_instr(OP_R, 5'd2, F_NONE, F_RGW | F_PCW | F_RET);

    tag = "load";
    chk(1'b1, 1'b1, OP_LD, 3'd0, 5'd0, F_IREQ | F_IRW);
    chk(1'b0, 1'b1, OP_LD, 3'd1, 5'd0, F_NONE);
    chk(1'b0, 1'b1, OP_BAD, 3'd2, 5'd0, F_SRC2);
    for (int i = 0; i < 3; i++) chk(1'b1, 1'b0, OP_BAD, 3'd3, 5'd0, F_DREQ);
    chk(1'b0, 1'b1, OP_BAD, 3'd3, 5'd0, F_DREQ);
    chk(1'b0, 1'b0, OP_BAD, 3'd4, 5'd0, F_RGW | F_PCW | F_RET | F_M2R);
    chk(1'b0, 1'b0, OP_BAD, 3'd0, 5'd0, F_IREQ);

    tag = "store";
    chk(1'b1, 1'b0, OP_ST, 3'd0, 5'd0, F_IREQ | F_IRW);
    chk(1'b0, 1'b0, OP_ST, 3'd1, 5'd0, F_NONE);
    chk(1'b0, 1'b0, OP_BAD, 3'd2, 5'd0, F_SRC2);
    chk(1'b0, 1'b1, OP_BAD, 3'd3, 5'd0, F_DREQ | F_DWE | F_PCW | F_RET);
    chk(1'b0, 1'b0, OP_BAD, 3'd0, 5'd0, F_IREQ);

    tag = "branch";
    chk(1'b1, 1'b0, OP_BR, 3'd0, 5'd0, F_IREQ | F_IRW);
    chk(1'b0, 1'b0, OP_BR, 3'd1, 5'd0, F_NONE);
    chk(1'b0, 1'b0, OP_BAD, 3'd2, 5'd1, F_BR | F_PCW | F_RET);
    chk(1'b0, 1'b0, OP_BAD, 3'd0, 5'd0, F_IREQ);

    tag = "itype";  alu_instr(OP_I,   5'd3, F_SRC2, F_RGW | F_PCW | F_RET);
    tag = "lui";    alu_instr(OP_LUI, 5'd4, F_SRC2, F_RGW | F_PCW | F_RET);
    tag = "auipc";  alu_instr(OP_AUI, 5'd5, F_SRC1 | F_SRC2, F_RGW | F_PCW | F_RET);
    tag = "jalr";   alu_instr(OP_JLR, 5'd6, F_SRC2, F_RGW | F_PCW | F_RET | F_JMP);
    tag = "jal_w3"; alu_instr(OP_JAL, 5'd6, F_SRC1 | F_SRC2, F_RGW | F_PCW | F_RET | F_JMP);

    tag = "illegal";
    chk(1'b1, 1'b0, OP_BAD, 3'd0, 5'd0, F_IREQ | F_IRW);
    chk(1'b0, 1'b0, OP_BAD, 3'd1, 5'd0, F_NONE);
    chk(1'b1, 1'b1, OP_R, 3'd5, 5'd0, F_FLT | F_ILL);
    chk(1'b1, 1'b1, OP_R, 3'd5, 5'd0, F_FLT | F_ILL);
    cyc(1'b0, 1'b0, 1'b0, OP_R, 1'b1, 3'd5, 5'd0, F_FLT | F_ILL);
    chk(1'b0, 1'b0, OP_R, 3'd0, 5'd0, F_IREQ);

    do_reset(2, "jal_w5");
    alu_instr(OP_JAL, 5'd6, F_SRC1 | F_SRC2, F_RGW | F_PCW | F_RET | F_JMP);
    tag = "reset_in_mem";
    chk(1'b1, 1'b0, OP_ST, 3'd0, 5'd0, F_IREQ | F_IRW);
    chk(1'b0, 1'b0, OP_ST, 3'd1, 5'd0, F_NONE);
    chk(1'b0, 1'b0, OP_ST, 3'd2, 5'd0, F_SRC2);
    chk(1'b0, 1'b0, OP_ST, 3'd3, 5'd0, F_DREQ | F_DWE);
    cyc(1'b0, 1'b0, 1'b1, OP_ST, 1'b1, 3'd3, 5'd0, F_DREQ | F_DWE);
    chk(1'b0, 1'b0, OP_ST, 3'd0, 5'd0, F_IREQ);

    do_reset(1, "imem_timeout");
    for (int i = 0; i < 4; i++) chk(1'b0, 1'b0, OP_R, 3'd0, 5'd0, F_IREQ);
    chk(1'b1, 1'b0, OP_R, 3'd5, 5'd0, F_FLT);
    chk(1'b1, 1'b0, OP_R, 3'd5, 5'd0, F_FLT);

    do_reset(1, "ready_wins");
    for (int i = 0; i < 3; i++) chk(1'b0, 1'b0, OP_JAL, 3'd0, 5'd0, F_IREQ);
    chk(1'b1, 1'b0, OP_JAL, 3'd0, 5'd0, F_IREQ | F_IRW);
    tag = "jal_disabled";
    chk(1'b0, 1'b0, OP_JAL, 3'd1, 5'd0, F_NONE);
    chk(1'b0, 1'b0, OP_R, 3'd5, 5'd0, F_FLT | F_ILL);

    do_reset(1, "dmem_timeout");
    chk(1'b1, 1'b0, OP_LD, 3'd0, 5'd0, F_IREQ | F_IRW);
    chk(1'b0, 1'b0, OP_LD, 3'd1, 5'd0, F_NONE);
    chk(1'b0, 1'b0, OP_LD, 3'd2, 5'd0, F_SRC2);
    for (int i = 0; i < 4; i++) chk(1'b0, 1'b0, OP_LD, 3'd3, 5'd0, F_DREQ);
    chk(1'b0, 1'b1, OP_LD, 3'd5, 5'd0, F_FLT);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
